// File: rtl/datapath.sv
// rtl/datapath.sv - register-file datapath with bus mux and 64-bit Z ALU.
// Optional DATAPATH_MULDIV_EN enables signed MUL/DIV; otherwise opcodes 4/5 yield 0.
module datapath (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] enable,
  input  logic [31:0] busSelect,
  input  logic [31:0] inPort,
  input  logic [31:0] MDataIn,
  input  logic        MD_Read,
  input  logic [3:0]  Control_Signals,
  output logic [31:0] busMuxOut
);

  logic [31:0] r [1:15];
  logic [31:0] hi, lo, pc, mdr, mar, ir, y, zh, zl;
  logic [63:0] alu;

  // Bus source mux; R0 and unmapped selects read as zero.
  always_comb begin
    busMuxOut = 32'd0;
    for (int i = 1; i < 16; i++)
      if (busSelect == 32'(i)) busMuxOut = r[i];
    case (busSelect)
      32'd16:  busMuxOut = hi;
      32'd17:  busMuxOut = lo;
      32'd18:  busMuxOut = zh;
      32'd19:  busMuxOut = zl;
      32'd20:  busMuxOut = pc;
      32'd21:  busMuxOut = mdr;
      32'd22:  busMuxOut = inPort;
      default: ;
    endcase
  end

  logic [31:0] a, b;
  logic [4:0]  amt;
  logic [63:0] dbl_r, dbl_l;
`ifdef DATAPATH_MULDIV_EN
  logic [31:0] quo, rem;
`endif

  assign a   = y;
  assign b   = busMuxOut;
  assign amt = b[4:0];

  always_comb begin
    alu   = 64'd0;
    dbl_r = {a, a} >> amt;
    dbl_l = {a, a} << amt;
`ifdef DATAPATH_MULDIV_EN
    quo = 32'd0;
    rem = 32'd0;
    if (b != 32'd0) begin
      quo = 32'($signed(a) / $signed(b));
      rem = 32'($signed(a) % $signed(b));
    end
`endif
    case (Control_Signals)
      4'd0:  alu = {32'd0, a + b};
      4'd1:  alu = {32'd0, a - b};
      4'd2:  alu = {32'd0, a & b};
      4'd3:  alu = {32'd0, a | b};
`ifdef DATAPATH_MULDIV_EN
      4'd4:  alu = 64'($signed(64'($signed(a))) * $signed(64'($signed(b))));
      4'd5:  alu = {rem, quo};
`else
      4'd4:  alu = 64'd0;
      4'd5:  alu = 64'd0;
`endif
      4'd6:  alu = {32'd0, a >> amt};
      4'd7:  alu = {32'd0, 32'($signed(a) >>> amt)};
      4'd8:  alu = {32'd0, a << amt};
      // Rotates via a doubled word so a zero amount returns A unchanged.
      4'd9:  alu = {32'd0, dbl_r[31:0]};
      4'd10: alu = {32'd0, dbl_l[63:32]};
      4'd11: alu = {32'd0, 32'd0 - b};
      4'd12: alu = {32'd0, ~b};
      default: alu = {32'd0, b};
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 1; i < 16; i++) r[i] <= 32'd0;
      hi  <= 32'd0;
      lo  <= 32'd0;
      pc  <= 32'd0;
      mdr <= 32'd0;
      mar <= 32'd0;
      ir  <= 32'd0;
      y   <= 32'd0;
      zh  <= 32'd0;
      zl  <= 32'd0;
    end else begin
      for (int i = 1; i < 16; i++)
        if (enable == 32'(i)) r[i] <= busMuxOut;
      case (enable)
        32'd16: hi  <= busMuxOut;
        32'd17: lo  <= busMuxOut;
        32'd20: pc  <= busMuxOut;
        32'd21: mdr <= MD_Read ? MDataIn : busMuxOut;
        32'd23: ir  <= busMuxOut;
        32'd24: {zh, zl} <= alu;
        32'd25: mar <= busMuxOut;
        32'd26: pc  <= pc + 32'd1;
        32'd27: y   <= busMuxOut;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath: register model plus expected-bus queue.
module tb_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] enable, busSelect, inPort, MDataIn;
  logic        MD_Read;
  logic [3:0]  Control_Signals;
  logic [31:0] busMuxOut;

  datapath dut (
    .clk(clk), .clr(clr), .enable(enable), .busSelect(busSelect),
    .inPort(inPort), .MDataIn(MDataIn), .MD_Read(MD_Read),
    .Control_Signals(Control_Signals), .busMuxOut(busMuxOut)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m [0:22];
  logic [31:0] m_y, m_ir, m_mar;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 23; i++) m[i] = 32'd0;
    m_y = 0; m_ir = 0; m_mar = 0;
  endtask

  function automatic logic [31:0] model_bus(input int sel);
    if (sel == 22) return inPort;
    if (sel >= 0 && sel <= 21) return m[sel];
    return 32'd0;
  endfunction

  function automatic logic [63:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] v;
    logic signed [63:0] p;
    v = a;
    case (op)
      0: return {32'd0, a + b};
      1: return {32'd0, a - b};
      2: return {32'd0, a & b};
      3: return {32'd0, a | b};
`ifdef DATAPATH_MULDIV_EN
      4: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p; end
      5: begin
        if (b == 0) return 64'd0;
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      end
`else
      4, 5: return 64'd0;
`endif
      6: return {32'd0, a >> b[4:0]};
      7: begin
        for (int i = 0; i < int'(b[4:0]); i++) v = {v[31], v[31:1]};
        return {32'd0, v};
      end
      8: return {32'd0, a << b[4:0]};
      9: begin
        for (int i = 0; i < int'(b[4:0]); i++) v = {v[0], v[31:1]};
        return {32'd0, v};
      end
      10: begin
        for (int i = 0; i < int'(b[4:0]); i++) v = {v[30:0], v[31]};
        return {32'd0, v};
      end
      11: return {32'd0, ~b + 32'd1};
      12: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  task automatic step(input int en, input int sel, input int op, input logic rd, input logic [31:0] md);
    logic [31:0] bv;
    logic [63:0] z;
    @(negedge clk);
    enable = en; busSelect = sel; Control_Signals = 4'(op); MD_Read = rd; MDataIn = md;
    bv = model_bus(sel);
    z  = alu_model(op, m_y, bv);
    if (en >= 1 && en <= 17) m[en] = bv;
    case (en)
      20: m[20] = bv;
      21: m[21] = rd ? md : bv;
      23: m_ir = bv;
      24: begin m[18] = z[63:32]; m[19] = z[31:0]; end
      25: m_mar = bv;
      26: m[20] = m[20] + 1;
      27: m_y = bv;
      default: ;
    endcase
    @(posedge clk);
    #1;
    enable = 0;
  endtask

  task automatic check_bus(input string tag, input int sel);
    @(negedge clk);
    enable = 0;
    busSelect = sel;
    exp_q.push_back(model_bus(sel));
    #1;
    check(tag, {32'd0, busMuxOut}, {32'd0, exp_q.pop_front()});
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < 23; s++) check_bus(tag, s);
    check({tag, "_ir"}, {32'd0, dut.ir}, {32'd0, m_ir});
    check({tag, "_y"}, {32'd0, dut.y}, {32'd0, m_y});
    check({tag, "_mar"}, {32'd0, dut.mar}, {32'd0, m_mar});
  endtask

  task automatic put(input int en, input logic [31:0] val);
    inPort = val;
    step(en, 22, 0, 1'b0, 32'd0);
  endtask

  logic [31:0] va [6];
  logic [31:0] vb [6];

  initial begin
    clr = 1'b1; enable = 0; busSelect = 0; inPort = 0; MDataIn = 0; MD_Read = 0; Control_Signals = 0;
    model_reset();
    #12 clr = 1'b0;
    check_all("reset");

    // PC increments three times from reset.
    for (int i = 0; i < 3; i++) step(26, 0, 0, 1'b0, 0);
    check_bus("pc_inc", 20);

    // MDR load from memory, then to IR.
    step(21, 0, 0, 1'b1, 32'h389A8000);
    check_bus("mdr", 21);
    step(23, 21, 0, 1'b0, 0);
    check("ir", {32'd0, dut.ir}, {32'd0, 32'h389A8000});

    // ROR scenario.
    step(21, 0, 0, 1'b1, 32'd1);
    step(3, 21, 0, 1'b0, 0);
    put(5, 4);
    put(1, 3);
    step(27, 3, 0, 1'b0, 0);
    step(24, 5, 9, 1'b0, 0);
    step(1, 19, 0, 1'b0, 0);
    check_bus("ror_r1", 1);
    check("ror_lit", {32'd0, m[1]}, 64'h10000000);

    // MUL scenario: Y = -1, B = 2.
    put(27, 32'hFFFFFFFF);
    put(6, 2);
    step(24, 6, 4, 1'b0, 0);
    check_bus("mul_hi", 18);
    check_bus("mul_lo", 19);

    // ALU sweep through all opcodes.
    va[0] = 32'h7;        vb[0] = 32'h3;
    va[1] = 32'h80000000; vb[1] = 32'd33;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'd2;
    va[3] = 32'h12345678; vb[3] = 32'd0;
    va[4] = 32'hFFFFFF9C; vb[4] = 32'd7;
    va[5] = $urandom;     vb[5] = $urandom | 32'h1;
    for (int op = 0; op < 16; op++)
      for (int k = 0; k < 6; k++) begin
        put(2, va[k]);
        step(27, 2, 0, 1'b0, 0);
        put(4, vb[k]);
        step(24, 4, op, 1'b0, 0);
        check_bus($sformatf("alu%0d_hi", op), 18);
        check_bus($sformatf("alu%0d_lo", op), 19);
      end

    // PC wrap.
    put(20, 32'hFFFFFFFF);
    step(26, 0, 0, 1'b0, 0);
    check_bus("pc_wrap", 20);

    // Fill registers, then idle and unlisted enables must not change anything.
    for (int i = 1; i < 18; i++) put(i, 32'hA000_0000 + i);
    put(25, 32'h55);
    step(0, 30, 3, 1'b0, 0);
    check_bus("sel30", 30);
    step(18, 5, 0, 1'b0, 0);
    step(22, 5, 0, 1'b0, 0);
    step(28, 5, 0, 1'b0, 0);
    step(0, 7, 0, 1'b0, 0);
    check_all("idle");

    // Asynchronous reset between edges.
    put(5, 7);
    @(negedge clk);
    #1 clr = 1'b1;
    #1 clr = 1'b0;
    model_reset();
    busSelect = 5;
    #1 check("async_r5", {32'd0, busMuxOut}, 64'd0);

    // Loads ignored while clr held across an edge.
    @(negedge clk);
    clr = 1'b1; enable = 5; busSelect = 22; inPort = 32'h9;
    @(posedge clk);
    #1;
    @(negedge clk);
    clr = 1'b0; enable = 0;
    check_all("clr_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all storage.
REQ-002 SHALL have port: clr  input  1  asynchronous active-high reset.
REQ-003 SHALL have port: enable  input  32  binary-encoded index of the one register that loads this edge; 0 = no load.
REQ-004 SHALL have port: busSelect  input  32  binary-encoded bus source index.
REQ-005 SHALL have port: inPort  input  32  external input-port data.
REQ-006 SHALL have port: MDataIn  input  32  memory read data.
REQ-007 SHALL have port: MD_Read  input  1  MDR input mux select; 1 = MDataIn, 0 = bus.
REQ-008 SHALL have port: Control_Signals  input  4  ALU opcode.
REQ-009 SHALL have port: busMuxOut  output  32  current bus value (combinational).
REQ-010 SHALL implement one clock with an asynchronous, active-high reset, as already decided.

Function
REQ-011 SHALL contain registers R0-R15, HI, LO, PC, MDR, MAR, IR, Y (32 bit each) and Z (64 bit: Zhigh, Zlow).
REQ-012 Enable index map: 1-15 = R1-R15, 16 = HI, 17 = LO, 20 = PC, 21 = MDR, 23 = IR, 24 = Z, 25 = MAR, 26 = PC increment, 27 = Y.
REQ-013 Enable handling: 0 and all unlisted indices load nothing; R0 SHALL read as constant zero.
REQ-014 Bus map: 0-15 = R0-R15, 16 = HI, 17 = LO, 18 = Zhigh, 19 = Zlow, 20 = PC, 21 = MDR, 22 = inPort; any other index SHALL drive 0.
REQ-015 Register loads: the selected register SHALL load busMuxOut on the rising clk edge.
REQ-016 MDR load: MDR SHALL load MD_Read ? MDataIn : busMuxOut.
REQ-017 Z load: Z SHALL load the 64-bit ALU result.
REQ-018 PC increment: enable = 26 SHALL set PC <= PC + 1, wrapping at 2^32.
REQ-019 ALU operands: A = Y, B = busMuxOut; the ALU SHALL be combinational.
REQ-020 Opcodes 0-2: 0 ADD, 1 SUB (A-B), 2 AND.
REQ-021 Opcodes 3-5: 3 OR, 4 MUL (signed 64-bit product), 5 DIV (Zlow = quotient, Zhigh = remainder, signed).
REQ-022 Opcodes 6-8: 6 SHR (logical), 7 SHRA (arithmetic), 8 SHL.
REQ-023 Opcodes 9-10: 9 ROR, 10 ROL; rotate amount = B[4:0].
REQ-024 Opcodes 11-15: 11 NEG (-B), 12 NOT (~B), 13-15 pass B.
REQ-025 Result width: non-MUL/DIV results SHALL occupy Zlow with Zhigh = 0; ADD/SUB SHALL wrap modulo 2^32.
REQ-026 Shift and rotate range: shift by >=32 SHALL use only B[4:0]; rotate by 0 SHALL return A unchanged.
REQ-027 Divide by zero SHALL yield Z = 0.

Reset
REQ-028 clr = 1 SHALL immediately clear every register, including PC, IR, MAR, Y and Z, to 0 regardless of clk.
REQ-029 While clr is held, all loads SHALL be ignored.
REQ-030 After reset, busMuxOut SHALL equal 0 for any valid register select.

Configuration
REQ-031 Macro DATAPATH_MULDIV_EN defined: opcodes 4 and 5 SHALL behave as in REQ-021.
REQ-032 Macro DATAPATH_MULDIV_EN undefined: opcodes 4 and 5 SHALL produce Z = 0, and no multiplier/divider SHALL be synthesized.

Verification
REQ-033 ROR: MDataIn=1 via MDR->R3, 4->R5, 3->R1; busSelect 3 / enable 27; busSelect 5 / enable 24 / op 9; busSelect 19 / enable 1 -> R1 = 0x10000000.
REQ-034 MDR load: MD_Read=1, MDataIn=0x389A8000, enable=21; then busSelect=21 -> busMuxOut = 0x389A8000; enable=23 -> IR = 0x389A8000.
REQ-035 PC increment: enable=26 three cycles from reset -> busSelect=20 gives 3.
REQ-036 Asynchronous reset: R5 = 7, pulse clr between edges -> busSelect=5 shows 0 before the next edge.
REQ-037 MUL: with DATAPATH_MULDIV_EN, Y = 0xFFFFFFFF, B = 2, op 4 -> Zhigh = 0xFFFFFFFF, Zlow = 0xFFFFFFFE.
REQ-038 Enable=0 and busSelect=30: no register changes, busMuxOut = 0.
